// File: rtl/tomasula_types.sv
// Shared types for the Tomasulo reservation stations:
// issue control word, operand entry and station state.
package tomasula_types;
   localparam int XLEN      = 32;
   localparam int ROB_TAG_W = 3;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE, WAIT, DISPATCH
   } rs_state_t;

   typedef struct packed {
      alu_op_t         op;
      logic [4:0]      src1_reg;
      logic            src1_valid;
      logic [4:0]      src2_reg;
      logic            src2_valid;
      logic [XLEN-1:0] src2_data;
      logic [2:0]      funct3;
      logic            funct7;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
   } ctl_word_t;

   typedef struct packed {
      logic                 ready;
      logic [ROB_TAG_W-1:0] tag;
      logic [XLEN-1:0]      value;
   } opnd_t;
endpackage

// File: rtl/rs_operand_slot.sv
// One reservation-station operand: issue-time source select
// (immediate / regfile / pending tag) plus CDB snoop.
module rs_operand_slot
   import tomasula_types::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 capture,
   input  logic                 snoop,
   input  logic                 use_imm,
   input  logic [XLEN-1:0]      imm,
   input  logic                 rf_ready,
   input  logic [XLEN-1:0]      rf_data,
   input  logic [ROB_TAG_W-1:0] rf_tag,
   input  logic                 cdb_valid,
   input  logic [ROB_TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]      cdb_data,
   output opnd_t                entry,
   output logic                 ready_next
);
   opnd_t nxt;
   logic  hit;

   always_comb begin
      nxt = entry;
      if (capture) begin
         if (use_imm)
            nxt = '{ready: 1'b1, tag: '0, value: imm};
         else if (rf_ready)
            nxt = '{ready: 1'b1, tag: '0, value: rf_data};
         else
            nxt = '{ready: 1'b0, tag: rf_tag, value: '0};
      end
      // Same-cycle bypass at issue and snoop while waiting share one path
      hit = (capture || snoop) && cdb_valid &&
            !nxt.ready && (nxt.tag == cdb_tag);
      if (hit) begin
         nxt.ready = 1'b1;
         nxt.value = cdb_data;
      end
   end

   assign ready_next = nxt.ready;

   always_ff @(posedge clk) begin
      if (rst || flush)
         entry <= '0;
      else
         entry <= nxt;
   end
endmodule

// File: rtl/reservation_station.sv
// Single-entry Tomasulo reservation station: holds one issued op
// until both operands are ready, then hands it to the ALU.
module reservation_station
   import tomasula_types::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 load,
   input  ctl_word_t            control_i,
   input  logic [ROB_TAG_W-1:0] rob_tag_i,
   input  logic                 rf_src1_ready,
   input  logic [XLEN-1:0]      rf_src1_data,
   input  logic [ROB_TAG_W-1:0] rf_src1_tag,
   input  logic                 rf_src2_ready,
   input  logic [XLEN-1:0]      rf_src2_data,
   input  logic [ROB_TAG_W-1:0] rf_src2_tag,
   input  logic                 cdb_valid,
   input  logic [ROB_TAG_W-1:0] cdb_tag,
   input  logic [XLEN-1:0]      cdb_data,
   output logic                 empty,
   output logic                 alu_valid,
   input  logic                 alu_ready,
   output alu_op_t              alu_op,
   output logic [2:0]           alu_funct3,
   output logic                 alu_funct7,
   output logic [XLEN-1:0]      alu_vj,
   output logic [XLEN-1:0]      alu_vk,
   output logic [ROB_TAG_W-1:0] alu_tag
);
   rs_state_t            state, state_nxt;
   opnd_t                opj, opk;
   logic                 rdy_j, rdy_k;
   logic                 capture, snoop;
   alu_op_t              op_q;
   logic [2:0]           f3_q;
   logic                 f7_q;
   logic [ROB_TAG_W-1:0] tag_q;
   logic                 unused_ctl;

   assign capture = (state == IDLE) && load;
   assign snoop   = (state == WAIT);

   // Register names and rd are tracked by the ROB, not here
   assign unused_ctl = ^{control_i.src1_reg, control_i.src2_reg,
                         control_i.rd};

   rs_operand_slot u_slot_j (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .capture    (capture),
      .snoop      (snoop),
      .use_imm    (!control_i.src1_valid),
      .imm        (control_i.pc),
      .rf_ready   (rf_src1_ready),
      .rf_data    (rf_src1_data),
      .rf_tag     (rf_src1_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .entry      (opj),
      .ready_next (rdy_j)
   );

   rs_operand_slot u_slot_k (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .capture    (capture),
      .snoop      (snoop),
      .use_imm    (!control_i.src2_valid),
      .imm        (control_i.src2_data),
      .rf_ready   (rf_src2_ready),
      .rf_data    (rf_src2_data),
      .rf_tag     (rf_src2_tag),
      .cdb_valid  (cdb_valid),
      .cdb_tag    (cdb_tag),
      .cdb_data   (cdb_data),
      .entry      (opk),
      .ready_next (rdy_k)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:
            if (load)
               state_nxt = (rdy_j && rdy_k) ? DISPATCH : WAIT;
         WAIT:
            if (rdy_j && rdy_k)
               state_nxt = DISPATCH;
         DISPATCH:
            if (alu_ready)
               state_nxt = IDLE;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state <= IDLE;
         op_q  <= OP_ADD;
         f3_q  <= '0;
         f7_q  <= 1'b0;
         tag_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            op_q  <= control_i.op;
            f3_q  <= control_i.funct3;
            f7_q  <= control_i.funct7;
            tag_q <= rob_tag_i;
         end
      end
   end

   assign empty      = (state == IDLE);
   assign alu_valid  = (state == DISPATCH);
   assign alu_op     = op_q;
   assign alu_funct3 = f3_q;
   assign alu_funct7 = f7_q;
   assign alu_vj     = opj.value;
   assign alu_vk     = opk.value;
   assign alu_tag    = tag_q;
endmodule

// File: tb/tb_reservation_station.sv
// Scoreboard bench for reservation_station: issue, CDB snoop,
// bypass, backpressure, flush and reset scenarios.
module tb_reservation_station;
   import tomasula_types::*;

   logic                 clk = 1'b0;
   logic                 rst, flush, load;
   ctl_word_t            control_i;
   logic [ROB_TAG_W-1:0] rob_tag_i;
   logic                 rf_src1_ready, rf_src2_ready;
   logic [XLEN-1:0]      rf_src1_data, rf_src2_data;
   logic [ROB_TAG_W-1:0] rf_src1_tag, rf_src2_tag;
   logic                 cdb_valid;
   logic [ROB_TAG_W-1:0] cdb_tag;
   logic [XLEN-1:0]      cdb_data;
   logic                 empty, alu_valid, alu_ready;
   alu_op_t              alu_op;
   logic [2:0]           alu_funct3;
   logic                 alu_funct7;
   logic [XLEN-1:0]      alu_vj, alu_vk;
   logic [ROB_TAG_W-1:0] alu_tag;

   typedef struct {
      alu_op_t     op;
      logic [2:0]  f3;
      logic        f7;
      logic [31:0] vj;
      logic [31:0] vk;
      logic [2:0]  tag;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;

   reservation_station dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .load          (load),
      .control_i     (control_i),
      .rob_tag_i     (rob_tag_i),
      .rf_src1_ready (rf_src1_ready),
      .rf_src1_data  (rf_src1_data),
      .rf_src1_tag   (rf_src1_tag),
      .rf_src2_ready (rf_src2_ready),
      .rf_src2_data  (rf_src2_data),
      .rf_src2_tag   (rf_src2_tag),
      .cdb_valid     (cdb_valid),
      .cdb_tag       (cdb_tag),
      .cdb_data      (cdb_data),
      .empty         (empty),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_op        (alu_op),
      .alu_funct3    (alu_funct3),
      .alu_funct7    (alu_funct7),
      .alu_vj        (alu_vj),
      .alu_vk        (alu_vk),
      .alu_tag       (alu_tag)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      assert (rst || !load || empty)
         else $error("load issued while station busy");

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic quiet();
      load = 1'b0; flush = 1'b0; cdb_valid = 1'b0;
      cdb_tag = '0; cdb_data = '0;
      rf_src1_ready = 1'b0; rf_src1_data = '0; rf_src1_tag = '0;
      rf_src2_ready = 1'b0; rf_src2_data = '0; rf_src2_tag = '0;
   endtask

   task automatic issue(input alu_op_t op, input logic [2:0] f3,
                        input logic f7, input logic s1v,
                        input logic s2v, input logic [31:0] s2d,
                        input logic [31:0] pc, input logic [2:0] tag);
      control_i = '0;
      control_i.op = op;
      control_i.funct3 = f3;
      control_i.funct7 = f7;
      control_i.src1_valid = s1v;
      control_i.src2_valid = s2v;
      control_i.src2_data = s2d;
      control_i.pc = pc;
      control_i.src1_reg = 5'd1;
      control_i.src2_reg = 5'd2;
      control_i.rd = 5'd3;
      rob_tag_i = tag;
      load = 1'b1;
   endtask

   task automatic test_reset();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=10", {empty, alu_valid});
      end
      checks++;
      if ({alu_op, alu_funct3, alu_funct7, alu_vj, alu_vk, alu_tag} !== '0) begin
         failures++;
         $display("FAIL reset_data vj=%h vk=%h tag=%0d exp=0",
                  alu_vj, alu_vk, alu_tag);
      end
   endtask

   task automatic test_ready_at_issue();
      quiet(); alu_ready = 1'b1;
      issue(OP_ADD, 3'd0, 1'b0, 1'b1, 1'b0, 32'h7, 32'h100, 3'd1);
      rf_src1_ready = 1'b1; rf_src1_data = 32'h5;
      sb.push_back('{OP_ADD, 3'd0, 1'b0, 32'h5, 32'h7, 3'd1});
      tick(); quiet();
      checks++;
      if ({empty, alu_valid} !== 2'b01) begin
         failures++;
         $display("FAIL ready_n1 got=%b exp=01", {empty, alu_valid});
      end
      checks++;
      if (sb.size() == 0) begin
         failures++; $display("FAIL ready_sb scoreboard empty");
      end else begin
         e = sb.pop_front();
         if ({alu_op, alu_funct3, alu_funct7, alu_vj, alu_vk, alu_tag} !==
             {e.op, e.f3, e.f7, e.vj, e.vk, e.tag}) begin
            failures++;
            $display("FAIL ready_data got vj=%h vk=%h tag=%0d exp vj=%h vk=%h tag=%0d",
                     alu_vj, alu_vk, alu_tag, e.vj, e.vk, e.tag);
         end
      end
      tick();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL ready_n2 got=%b exp=10", {empty, alu_valid});
      end
   endtask

   task automatic test_pending();
      quiet(); alu_ready = 1'b1;
      issue(OP_SUB, 3'd0, 1'b1, 1'b1, 1'b0, 32'h9, 32'h104, 3'd2);
      rf_src1_tag = 3'd3;
      sb.push_back('{OP_SUB, 3'd0, 1'b1, 32'hDEAD, 32'h9, 3'd2});
      tick(); quiet();
      cdb_valid = 1'b1; cdb_tag = 3'd2; cdb_data = 32'hBAD;
      checks++;
      if ({empty, alu_valid} !== 2'b00) begin
         failures++;
         $display("FAIL pend_wait got=%b exp=00", {empty, alu_valid});
      end
      tick(); quiet();
      tick();
      checks++;
      if (alu_valid !== 1'b0) begin
         failures++;
         $display("FAIL pend_wrong_tag got=%b exp=0", alu_valid);
      end
      cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'hDEAD;
      tick(); quiet();
      checks++;
      if (alu_valid !== 1'b1) begin
         failures++;
         $display("FAIL pend_dispatch got=%b exp=1", alu_valid);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++; $display("FAIL pend_sb scoreboard empty");
      end else begin
         e = sb.pop_front();
         if ({alu_op, alu_funct3, alu_funct7, alu_vj, alu_vk, alu_tag} !==
             {e.op, e.f3, e.f7, e.vj, e.vk, e.tag}) begin
            failures++;
            $display("FAIL pend_data got vj=%h vk=%h tag=%0d exp vj=%h vk=%h tag=%0d",
                     alu_vj, alu_vk, alu_tag, e.vj, e.vk, e.tag);
         end
      end
      tick();
   endtask

   task automatic test_bypass();
      quiet(); alu_ready = 1'b1;
      issue(OP_XOR, 3'd4, 1'b0, 1'b1, 1'b1, 32'h0, 32'h108, 3'd5);
      rf_src1_tag = 3'd4;
      rf_src2_ready = 1'b1; rf_src2_data = 32'h22;
      cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 32'h11;
      sb.push_back('{OP_XOR, 3'd4, 1'b0, 32'h11, 32'h22, 3'd5});
      tick(); quiet();
      checks++;
      if (alu_valid !== 1'b1) begin
         failures++;
         $display("FAIL bypass_n1 got=%b exp=1", alu_valid);
      end
      checks++;
      if (sb.size() == 0) begin
         failures++; $display("FAIL bypass_sb scoreboard empty");
      end else begin
         e = sb.pop_front();
         if ({alu_op, alu_funct3, alu_funct7, alu_vj, alu_vk, alu_tag} !==
             {e.op, e.f3, e.f7, e.vj, e.vk, e.tag}) begin
            failures++;
            $display("FAIL bypass_data got vj=%h vk=%h tag=%0d exp vj=%h vk=%h tag=%0d",
                     alu_vj, alu_vk, alu_tag, e.vj, e.vk, e.tag);
         end
      end
      tick();
   endtask

   task automatic test_dual_match();
      quiet(); alu_ready = 1'b1;
      issue(OP_AND, 3'd7, 1'b0, 1'b1, 1'b1, 32'h0, 32'h10C, 3'd7);
      rf_src1_tag = 3'd6; rf_src2_tag = 3'd6;
      sb.push_back('{OP_AND, 3'd7, 1'b0, 32'h42, 32'h42, 3'd7});
      tick(); quiet();
      checks++;
      if (alu_valid !== 1'b0) begin
         failures++;
         $display("FAIL dual_wait got=%b exp=0", alu_valid);
      end
      cdb_valid = 1'b1; cdb_tag = 3'd6; cdb_data = 32'h42;
      tick(); quiet();
      checks++;
      if (sb.size() == 0 || alu_valid !== 1'b1) begin
         failures++;
         $display("FAIL dual_dispatch valid=%b exp=1", alu_valid);
      end else begin
         e = sb.pop_front();
         if ({alu_op, alu_funct3, alu_funct7, alu_vj, alu_vk, alu_tag} !==
             {e.op, e.f3, e.f7, e.vj, e.vk, e.tag}) begin
            failures++;
            $display("FAIL dual_data got vj=%h vk=%h exp vj=%h vk=%h",
                     alu_vj, alu_vk, e.vj, e.vk);
         end
      end
      tick();
   endtask

   task automatic test_backpressure();
      quiet(); alu_ready = 1'b0;
      issue(OP_SLT, 3'd2, 1'b0, 1'b0, 1'b1, 32'h0, 32'h200, 3'd4);
      rf_src2_ready = 1'b1; rf_src2_data = 32'h33;
      sb.push_back('{OP_SLT, 3'd2, 1'b0, 32'h200, 32'h33, 3'd4});
      tick(); quiet();
      if (sb.size() != 0) e = sb.pop_front();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({empty, alu_valid, alu_op, alu_funct3, alu_vj, alu_vk, alu_tag} !==
             {2'b01, e.op, e.f3, e.vj, e.vk, e.tag}) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d e/v=%b%b vj=%h vk=%h tag=%0d exp vj=%h vk=%h tag=%0d",
                     i, empty, alu_valid, alu_vj, alu_vk, alu_tag,
                     e.vj, e.vk, e.tag);
         end
         cdb_valid = 1'b1; cdb_tag = 3'(i); cdb_data = 32'hFFFF;
         tick(); quiet();
      end
      alu_ready = 1'b1;
      tick();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL bp_release got=%b exp=10", {empty, alu_valid});
      end
   endtask

   task automatic test_flush();
      quiet(); alu_ready = 1'b1;
      issue(OP_OR, 3'd6, 1'b0, 1'b1, 1'b0, 32'h1, 32'h300, 3'd3);
      rf_src1_tag = 3'd5;
      tick(); quiet();
      flush = 1'b1;
      tick(); quiet();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL flush_wait got=%b exp=10", {empty, alu_valid});
      end
      cdb_valid = 1'b1; cdb_tag = 3'd5; cdb_data = 32'h55;
      tick(); quiet();
      tick();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL flush_stale got=%b exp=10", {empty, alu_valid});
      end
      alu_ready = 1'b0;
      issue(OP_SLL, 3'd1, 1'b0, 1'b0, 1'b0, 32'h2, 32'h304, 3'd6);
      tick(); quiet();
      checks++;
      if (alu_valid !== 1'b1) begin
         failures++;
         $display("FAIL flush_pre_disp got=%b exp=1", alu_valid);
      end
      flush = 1'b1;
      tick(); quiet();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL flush_disp got=%b exp=10", {empty, alu_valid});
      end
      issue(OP_ADD, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3, 32'h308, 3'd1);
      flush = 1'b1;
      tick(); quiet();
      tick();
      checks++;
      if ({empty, alu_valid} !== 2'b10) begin
         failures++;
         $display("FAIL flush_drop_load got=%b exp=10", {empty, alu_valid});
      end
   endtask

   task automatic test_reset_dispatch();
      quiet(); alu_ready = 1'b0;
      issue(OP_SRA, 3'd5, 1'b1, 1'b0, 1'b0, 32'hABCD, 32'h400, 3'd7);
      tick(); quiet();
      checks++;
      if (alu_valid !== 1'b1) begin
         failures++;
         $display("FAIL rst_pre_disp got=%b exp=1", alu_valid);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({empty, alu_valid, alu_op, alu_funct3, alu_funct7,
           alu_vj, alu_vk, alu_tag} !== {2'b10, 75'd0}) begin
         failures++;
         $display("FAIL rst_disp e/v=%b%b op=%0d vj=%h vk=%h tag=%0d exp 10/0",
                  empty, alu_valid, alu_op, alu_vj, alu_vk, alu_tag);
      end
   endtask

   initial begin
      quiet();
      rst = 1'b1; alu_ready = 1'b0;
      control_i = '0; rob_tag_i = '0;
      tick(); tick();
      test_reset();
      rst = 1'b0;
      tick();
      test_ready_at_issue();
      test_pending();
      test_bypass();
      test_dual_match();
      test_backpressure();
      test_flush();
      test_reset_dispatch();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_drain left=%0d exp=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- Single-entry Tomasulo reservation station sitting directly downstream of the issue queue.
- Instantiated four times, as res1..res4. Each instance drives its resN_empty into the issue queue and captures the issued control word when resN_load is high.
- Holds the instruction until both operands are available, either from the regfile or by snooping the CDB. Then dispatches to its ALU with a valid/ready handshake and frees itself.

Parameters:
- XLEN, 32, operand/data width
- ROB_TAG_W, 3, ROB entry tag width (8-entry ROB)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  mispredict flush; discards held entry
- load  in  1  resN_load from issue queue
- control_i  in  ctl_word  control word issued this cycle (op, src1/src2 reg+valid, src2_data, funct3, funct7, rd, pc)
- rob_tag_i  in  ROB_TAG_W  ROB tag allocated to this instruction (same cycle as load)
- rf_src1_ready  in  1  regfile value for src1 is committed (no pending producer)
- rf_src1_data  in  XLEN  regfile src1 value
- rf_src1_tag  in  ROB_TAG_W  ROB tag of pending src1 producer
- rf_src2_ready, rf_src2_data, rf_src2_tag  in  1/XLEN/ROB_TAG_W  same for src2
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  ROB_TAG_W  CDB producing tag
- cdb_data  in  XLEN  CDB result
- empty  out  1  station free (resN_empty)
- alu_valid  out  1  dispatch request
- alu_ready  in  1  ALU accepts this cycle
- alu_op  out  ctl op enum  operation
- alu_funct3  out  3  funct3
- alu_funct7  out  1  funct7
- alu_vj  out  XLEN  operand 1
- alu_vk  out  XLEN  operand 2
- alu_tag  out  ROB_TAG_W  destination ROB tag

Behaviour:
- Clock and reset are decided: one clock (clk); reset (rst) is synchronous and active-high.
- States:
  - IDLE: empty=1.
  - WAIT: operands pending.
  - DISPATCH: alu_valid=1, waiting for alu_ready.
- Reset values:
  - state=IDLE, empty=1, alu_valid=0.
  - All held fields, vj/vk/qj/qk and alu_* data outputs = 0.
  - rj/rk ready flags = 0.
- empty is a combinational decode of state==IDLE only; it is never a function of load.
- IDLE, load=1: capture control_i fields and rob_tag_i. Per operand:
  - src1_valid=0: vj=pc, ready.
  - src1_valid=1 and rf_src1_ready=1: vj=rf_src1_data, ready.
  - Otherwise: qj=rf_src1_tag, not ready.
  - src2_valid=0: vk=src2_data (immediate), ready.
  - Otherwise: same rule as src1, using rf_src2_*.
  - Same-cycle CDB bypass: a not-ready operand whose tag equals cdb_tag with cdb_valid=1 is captured as ready with cdb_data.
  - Next state: DISPATCH if both operands are ready after bypass, else WAIT.
- load while not IDLE: protocol violation; ignored. Verification flags it with an assertion.
- WAIT:
  - Each cycle with cdb_valid, every not-ready operand whose q equals cdb_tag latches cdb_data and becomes ready. Both operands may match one broadcast.
  - Transition to DISPATCH on the cycle after both operands are ready. This gives one cycle minimum from the final capture to alu_valid.
- DISPATCH:
  - alu_valid=1 and all alu_* outputs stable until accepted.
  - alu_ready=1 → IDLE next cycle; empty=1 the following cycle.
- Best-case latency: load in cycle N, alu_valid in N+1, freed (empty=1) in N+2 if alu_ready=1 in N+1.
- flush: highest priority after rst. Forces IDLE next cycle from any state; a load in the same cycle is dropped. alu_valid is not held across flush.
- CDB events in IDLE or DISPATCH have no effect.
- Tags compare over the full ROB_TAG_W width; no wrap-around handling is needed because the ROB guarantees live tags are unique.

Decomposition:
- rs_state_t enum (IDLE/WAIT/DISPATCH) and the operand-entry struct {ready, tag, value} go in tomasula_types, alongside ctl_word.
- One natural sub-module: rs_operand_slot. It holds one operand's ready/tag/value, implements the load-time select plus CDB snoop, and is instantiated twice.

Test Plan:
- Both operands ready at issue: load with rf_src1_ready=1 (0x5), src2_valid=0 and src2_data=0x7, alu_ready=1 → alu_valid in cycle N+1 with vj=5, vk=7, alu_tag=rob_tag_i; empty=1 in N+2.
- Pending operand: rf_src1_ready=0, tag=3; CDB tag=3 data=0xDEAD three cycles later → alu_valid one cycle after the broadcast with vj=0xDEAD. A broadcast with tag=2 beforehand changes nothing.
- Same-cycle bypass: load with src1 pending tag=4 while cdb_valid, tag=4, data=0x11 → vj=0x11 and alu_valid in N+1.
- Dual match: both sources pending on tag=6; single broadcast data=0x42 → vj=vk=0x42, dispatch next cycle.
- Backpressure: alu_ready held 0 for 4 cycles → alu_valid and outputs stable, empty=0 throughout; released on alu_ready=1.
- Flush/reset mid-operation: flush in WAIT and again in DISPATCH → empty=1 and alu_valid=0 next cycle; a later CDB match with the stale tag does not cause dispatch. rst in DISPATCH → all outputs at reset values next cycle.
